seg_scan_scheduler: RTL
=======================

Name: seg_scan_scheduler

Overview:
Sequences the shared 4-digit 7-segment display between the game's score sources. Selects the source for the current game phase: high score when idle, live score while playing, and blinking score alternating with high score at game over. Time-multiplexes the digits and encodes BCD to segments. Sits between the score/high-score BCD registers and the board AN/SEGMENT pins, and replaces ad-hoc per-source display logic.

Parameters:
SCAN_CYCLES, 50000, clk cycles each digit is driven; frame = 4*SCAN_CYCLES
BLINK_FRAMES, 64, frames per blink half-period in game-over score view
HOLD_FRAMES, 128, frames each game-over view (score / high score) is held

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
game_state  in  2  0=idle, 1=play, 2=over, 3=treated as idle
score_bcd  in  16  live score, 4 BCD nibbles, [3:0]=units
hi_bcd  in  16  high score, same format
SEGMENT  out  8  active-low segments, bit7=a … bit1=g, bit0=dp
AN  out  4  active-low digit enables, AN[0]=units digit

Behaviour:
- Reset (async, immediate, no clock needed): AN=4'b1111, SEGMENT=8'hFF, scan_cnt=0, digit index=0, state=S_IDLE, blink phase=on, frame/hold counters=0.
- Scan: scan_cnt counts 0..SCAN_CYCLES-1 and wraps. A tick occurs on the cycle scan_cnt==SCAN_CYCLES-1.
- On each tick: register AN/SEGMENT for the current digit index, then increment the index mod 4. AN one-hot low: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
- After reset release, the first tick is at the SCAN_CYCLES-th rising edge. AN/SEGMENT are stable between ticks.
- Frame start: a tick with index==0. Only at frame start:
  - game_state is sampled and the state FSM is updated;
  - the selected source (score_bcd or hi_bcd) is snapshotted into a 16-bit frame register;
  - frame, blink and hold counters advance.
  Digit 0 of the frame uses the value sampled on that same cycle. Source or game_state changes mid-frame have no effect until the next frame start (no tearing).
- FSM (evaluated at frame start):
  - S_IDLE: source=hi_bcd. dp lit on digit 0 (bit0=0). No blanking.
  - S_PLAY: source=score_bcd. Leading-zero suppression: digit k (k=1..3) shows SEGMENT=FF when it and all higher nibbles are 0. AN is still driven. Digit 0 is always shown.
  - S_OVER_SCORE: source=score_bcd. Blink phase toggles every BLINK_FRAMES frames. In the off phase AN=1111 for the whole frame.
  - S_OVER_HI: source=hi_bcd, steady.
  - Transitions:
    - game_state 0/3 → S_IDLE and game_state 1 → S_PLAY, from any state.
    - game_state 2 from S_IDLE or S_PLAY → S_OVER_SCORE, with hold=0 and phase=on.
    - In S_OVER_*: hold_cnt counts frames. When it reaches HOLD_FRAMES, switch S_OVER_SCORE↔S_OVER_HI, hold=0, and phase=on on entry to S_OVER_SCORE.
    - The new state applies to the frame starting on that tick.
- Encoding (SEGMENT, dp off):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
  - Nibble >9 shows "-" = FD.
  - dp on clears bit0.
- Counters: scan_cnt width is clog2(SCAN_CYCLES). Blink and hold counters saturate-free and wrap only via the rules above.
- Reset asserted mid-frame: outputs go to reset values asynchronously. The scan restarts from idx0 after release.

Test Plan:
Use SCAN_CYCLES=4, BLINK_FRAMES=2, HOLD_FRAMES=4 throughout.
1. Reset held then released → AN=1111/SEGMENT=FF for edges 1-3. Edge 4: AN=1110. AN then steps 1101, 1011, 0111 every 4 cycles.
2. game_state=1, score_bcd=16'h0042 → per frame: idx0 SEG=25, idx1 SEG=99, idx2 and idx3 SEG=FF with AN=1011/0111. With score 16'h0000, only digit 0 shows 03.
3. game_state=0, hi_bcd=16'h1234 → idx0 SEG=98 (4 with dp), idx1 0D, idx2 25, idx3 9F.
4. game_state 1→2, score=16'h0007, hi=16'h0099 → frames 1-2 show score, frames 3-4 have AN=1111, then 4 frames of hi steady (idx0=idx1=09), then score view again with phase on.
5. score_bcd changes 0x0001→0x0002 during idx1 → rest of that frame unchanged. Next frame idx0 SEG=25. A game_state change mid-frame likewise applies only at the next idx0 tick.
6. Nibble 4'hA in score → that digit SEG=FD. Async reset pulse between clock edges mid-frame → AN=1111 and SEGMENT=FF immediately.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if
// Bundles the score-display signals between the game logic and the display
// scheduler.
//   game_state : 0=idle, 1=play, 2=over, 3=idle
//   score_bcd  : live score, 4 BCD nibbles, [3:0]=units
//   hi_bcd     : high score, same format
//   SEGMENT    : active-low segments, bit7=a .. bit1=g, bit0=dp
//   AN         : active-low digit enables, AN[0]=units digit
// master = score sources / board side, slave = seg_scan_scheduler.
interface seg_scan_if;
    logic [1:0]  game_state;
    logic [15:0] score_bcd;
    logic [15:0] hi_bcd;
    logic [7:0]  SEGMENT;
    logic [3:0]  AN;

    modport master (
        output game_state,
        output score_bcd,
        output hi_bcd,
        input  SEGMENT,
        input  AN
    );

    modport slave (
        input  game_state,
        input  score_bcd,
        input  hi_bcd,
        output SEGMENT,
        output AN
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
// Drives the shared 4-digit 7-segment display.
// The source is chosen from the game phase:
//   - idle: high score, with the decimal point on the units digit.
//   - play: live score, with leading zeros suppressed.
//   - game over: a blinking score view alternates with a steady high-score view.
// The scheduler time-multiplexes the four digits and encodes BCD to segments.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : seg_scan_if.slave
//           inputs:  game_state, score_bcd, hi_bcd
//           outputs: SEGMENT, AN (both registered)
// The phase and source are only sampled at frame start, when digit 0 is
// about to be driven, so a frame never mixes two sources.
module seg_scan_scheduler #(
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int HOLD_FRAMES  = 128
) (
    input  logic        clk,
    input  logic        reset,
    seg_scan_if.slave   bus
);
    localparam int SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
    localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PLAY       = 2'd1,
        S_OVER_SCORE = 2'd2,
        S_OVER_HI    = 2'd3
    } state_t;

    // BCD nibble to active-low segments; anything above 9 shows a dash.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = 8'hFD;
        endcase
        return seg;
    endfunction

    // Returns {AN, SEGMENT} for digit d of frame value fv in view st.
    function automatic logic [11:0] digit_drive(input state_t st, input logic [15:0] fv,
                                                input logic phase_on, input logic [1:0] d);
        logic [3:0] nib;
        logic [7:0] seg;
        logic [3:0] an;
        logic       lz_blank;
        nib = 4'(fv >> {d, 2'b00});
        seg = seg_encode(nib);
        an  = ~(4'b0001 << d);
        // The shift drops the lower digits, so zero means this digit and
        // every higher digit are 0.
        lz_blank = (d != 2'd0) && ((fv >> {d, 2'b00}) == 16'd0);
        case (st)
            S_IDLE: seg = (d == 2'd0) ? {seg[7:1], 1'b0} : seg;
            S_PLAY: seg = lz_blank ? 8'hFF : seg;
            S_OVER_SCORE: begin
                an  = phase_on ? an  : 4'b1111;
                seg = phase_on ? seg : 8'hFF;
            end
            default: seg = seg;
        endcase
        return {an, seg};
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         idx_r;
    state_t             state_r;
    logic [15:0]        frame_r;
    logic               phase_on_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [3:0]         an_r;
    logic [7:0]         seg_r;

    logic               tick_s;
    logic               frame_start_s;
    state_t             state_nx_s;
    logic               phase_nx_s;
    logic [BLINK_W-1:0] blink_nx_s;
    logic [HOLD_W-1:0]  hold_nx_s;
    logic [15:0]        frame_nx_s;
    logic [11:0]        drive_s;

    assign tick_s        = (scan_cnt_r == SCAN_LAST);
    assign frame_start_s = tick_s && (idx_r == 2'd0);

    // Next view state and counters, applied only at frame start.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_on_r;
        blink_nx_s = blink_cnt_r;
        hold_nx_s  = hold_cnt_r;
        case (bus.game_state)
            2'd1: begin
                state_nx_s = S_PLAY;
                phase_nx_s = 1'b1;
                blink_nx_s = '0;
                hold_nx_s  = '0;
            end
            2'd2: begin
                case (state_r)
                    S_OVER_SCORE: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_nx_s = S_OVER_HI;
                            phase_nx_s = 1'b1;
                            blink_nx_s = '0;
                            hold_nx_s  = '0;
                        end else begin
                            hold_nx_s = hold_cnt_r + HOLD_W'(1);
                            if (blink_cnt_r == BLINK_LAST) begin
                                blink_nx_s = '0;
                                phase_nx_s = ~phase_on_r;
                            end else begin
                                blink_nx_s = blink_cnt_r + BLINK_W'(1);
                            end
                        end
                    end
                    S_OVER_HI: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_nx_s = S_OVER_SCORE;
                            phase_nx_s = 1'b1;
                            blink_nx_s = '0;
                            hold_nx_s  = '0;
                        end else begin
                            hold_nx_s = hold_cnt_r + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_nx_s = S_OVER_SCORE;
                        phase_nx_s = 1'b1;
                        blink_nx_s = '0;
                        hold_nx_s  = '0;
                    end
                endcase
            end
            default: begin
                state_nx_s = S_IDLE;
                phase_nx_s = 1'b1;
                blink_nx_s = '0;
                hold_nx_s  = '0;
            end
        endcase
    end

    assign frame_nx_s = ((state_nx_s == S_PLAY) || (state_nx_s == S_OVER_SCORE))
                        ? bus.score_bcd : bus.hi_bcd;

    // Digit 0 must already reflect the view chosen on this tick, so it uses
    // the next-state values instead of the registers.
    assign drive_s = frame_start_s
                     ? digit_drive(state_nx_s, frame_nx_s, phase_nx_s, idx_r)
                     : digit_drive(state_r, frame_r, phase_on_r, idx_r);

    // Scan timing, view FSM, frame snapshot and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_r  <= '0;
            idx_r       <= 2'd0;
            state_r     <= S_IDLE;
            frame_r     <= 16'd0;
            phase_on_r  <= 1'b1;
            blink_cnt_r <= '0;
            hold_cnt_r  <= '0;
            an_r        <= 4'b1111;
            seg_r       <= 8'hFF;
        end else begin
            scan_cnt_r <= tick_s ? '0 : scan_cnt_r + SCAN_W'(1);
            if (tick_s) begin
                an_r  <= drive_s[11:8];
                seg_r <= drive_s[7:0];
                idx_r <= idx_r + 2'd1;
            end
            if (frame_start_s) begin
                state_r     <= state_nx_s;
                frame_r     <= frame_nx_s;
                phase_on_r  <= phase_nx_s;
                blink_cnt_r <= blink_nx_s;
                hold_cnt_r  <= hold_nx_s;
            end
        end
    end

    assign bus.AN      = an_r;
    assign bus.SEGMENT = seg_r;
endmodule
